// File: rtl/regex_stream_feeder.sv
// rtl/regex_stream_feeder.sv - byte-to-bit serializer feeding the bit-serial regex matcher
// Optional: define REGEX_FEED_UNANCHORED_EN to inject a start token on every bit (substring search).
module regex_stream_feeder #(
    parameter int DATA_W       = 8,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int FLUSH_CYCLES = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bit_o,
    output logic              tok_o,
    output logic              bit_valid,
    output logic              sof_o,
    output logic              busy
);
    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FCW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATA_W - 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT, FLUSH} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] sreg;
    logic [BCW-1:0]    bit_cnt;
    logic [FCW-1:0]    flush_cnt;
    logic              last_q;
    logic              first_q;
    logic              rdy_en;
    logic              accept;
    logic              byte_end;

    assign accept   = in_valid && in_ready;
    assign byte_end = (state == SHIFT) && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (byte_end) begin
                    if (last_q)      state_nxt = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
                    else if (accept) state_nxt = SHIFT;
                    else             state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (accept) state_nxt = SHIFT;
            end
            FLUSH: begin
                if (flush_cnt == FLUSH_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rdy_en holds in_ready low until the first clock after reset release
    always_comb begin
        in_ready  = 1'b0;
        bit_valid = 1'b0;
        bit_o     = 1'b0;
        sof_o     = 1'b0;
        case (state)
            IDLE:  in_ready = rdy_en;
            SHIFT: begin
                bit_valid = 1'b1;
                bit_o     = MSB_FIRST ? sreg[DATA_W-1] : sreg[0];
                sof_o     = first_q && (bit_cnt == '0);
                in_ready  = (bit_cnt == BIT_LAST) && !last_q;
            end
            WAIT:  in_ready = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

`ifdef REGEX_FEED_UNANCHORED_EN
    assign tok_o = bit_valid;
`else
    assign tok_o = sof_o;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg      <= '0;
            bit_cnt   <= '0;
            flush_cnt <= '0;
            last_q    <= 1'b0;
            first_q   <= 1'b0;
            rdy_en    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                sreg    <= in_data;
                last_q  <= in_last;
                first_q <= (state == IDLE);
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                sreg    <= MSB_FIRST ? {sreg[DATA_W-2:0], 1'b0} : {1'b0, sreg[DATA_W-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_regex_stream_feeder.sv
// tb/tb_regex_stream_feeder.sv - bench for regex_stream_feeder (default and LSB-first/no-flush instances)
module tb_regex_stream_feeder;
`ifdef REGEX_FEED_UNANCHORED_EN
    localparam bit UNANCH = 1'b1;
`else
    localparam bit UNANCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data_a = '0, in_data_b = '0;
    logic       in_last_a = 1'b0, in_last_b = 1'b0;
    logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic       in_ready_a, bit_o_a, tok_o_a, bit_valid_a, sof_o_a, busy_a;
    logic       in_ready_b, bit_o_b, tok_o_b, bit_valid_b, sof_o_b, busy_b;

    int total = 0;
    int bad   = 0;

    // string-level model: bits remaining in current byte, flush cycles remaining, string open
    logic [7:0] m_byte [2];
    int         m_left [2];
    int         m_flush[2];
    logic       m_last [2];
    logic       m_first[2];
    logic       m_instr[2];
    logic       m_start[2];
    int         m_acc  [2];

    always #5 clk = ~clk;

    regex_stream_feeder dut_a (
        .clk(clk), .reset(reset), .in_data(in_data_a), .in_last(in_last_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .bit_o(bit_o_a), .tok_o(tok_o_a), .bit_valid(bit_valid_a),
        .sof_o(sof_o_a), .busy(busy_a)
    );

    regex_stream_feeder #(.DATA_W(8), .MSB_FIRST(1'b0), .FLUSH_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data_b), .in_last(in_last_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .bit_o(bit_o_b), .tok_o(tok_o_b), .bit_valid(bit_valid_b),
        .sof_o(sof_o_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready(input int i);
        if (!m_start[i])      return 1'b0;
        else if (m_left[i] > 0) return (m_left[i] == 1) && !m_last[i];
        else if (m_flush[i] > 0) return 1'b0;
        else                  return 1'b1;
    endfunction

    function automatic logic m_busy(input int i);
        return (m_left[i] > 0) || (m_flush[i] > 0) || m_instr[i];
    endfunction

    // {in_ready, bit_valid, bit_o, tok_o, sof_o, busy}
    function automatic logic [5:0] m_exp(input int i);
        logic bv, b, sf, tk;
        int p;
        bv = (m_left[i] > 0);
        b = 1'b0;
        sf = 1'b0;
        if (bv) begin
            p  = 8 - m_left[i];
            b  = (i == 0) ? m_byte[i][7-p] : m_byte[i][p];
            sf = m_first[i] && (p == 0);
        end
        tk = UNANCH ? bv : sf;
        return {m_ready(i), bv, b, tk, sf, m_busy(i)};
    endfunction

    task automatic m_step(input int i, input logic v, input logic [7:0] d, input logic l);
        logic acc;
        acc = v && m_ready(i);
        if (m_left[i] > 0) begin
            m_left[i]--;
            if (m_left[i] == 0 && m_last[i]) begin
                m_instr[i] = 1'b0;
                m_flush[i] = (i == 0) ? 22 : 0;
            end
        end else if (m_flush[i] > 0) begin
            m_flush[i]--;
        end
        if (acc) begin
            m_byte[i]  = d;
            m_last[i]  = l;
            m_first[i] = !m_instr[i];
            m_instr[i] = 1'b1;
            m_left[i]  = 8;
            m_acc[i]++;
        end
        m_start[i] = 1'b1;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 2; i++) begin
            m_byte[i] = '0; m_left[i] = 0; m_flush[i] = 0; m_last[i] = 1'b0;
            m_first[i] = 1'b0; m_instr[i] = 1'b0; m_start[i] = 1'b0;
        end
    endtask

    initial begin
        m_clear();
        m_acc[0] = 0;
        m_acc[1] = 0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_clear();
            else begin
                m_step(0, in_valid_a, in_data_a, in_last_a);
                m_step(1, in_valid_b, in_data_b, in_last_b);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cmp_a", {in_ready_a, bit_valid_a, bit_o_a, tok_o_a, sof_o_a, busy_a}, m_exp(0));
            chk("cmp_b", {in_ready_b, bit_valid_b, bit_o_b, tok_o_b, sof_o_b, busy_b}, m_exp(1));
        end
    end

    // called at a negedge; returns at the negedge following the accept edge
    task automatic send(input int i, input logic [7:0] d, input logic l);
        int c0;
        c0 = m_acc[i];
        if (i == 0) begin in_data_a = d; in_last_a = l; in_valid_a = 1'b1; end
        else        begin in_data_b = d; in_last_b = l; in_valid_b = 1'b1; end
        for (int n = 0; n < 200 && m_acc[i] == c0; n++) @(negedge clk);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        chk("send_accept", m_acc[i] - c0, 1);
    endtask

    task automatic wait_idle(input int i);
        for (int n = 0; n < 200 && m_busy(i); n++) @(negedge clk);
        chk("idle_reached", m_busy(i), 0);
    endtask

    initial begin
        logic [7:0]  lit;
        logic [15:0] pat;
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", {in_ready_a, bit_valid_a, bit_o_a, tok_o_a, sof_o_a, busy_a}, 0);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", in_ready_a, 1);

        // 0x35 last, MSB first, then 22-cycle flush
        send(0, 8'h35, 1'b1);
        lit = 8'b00110101;
        for (int k = 0; k < 8; k++) begin
            chk("t1_bit", bit_o_a, lit[7-k]);
            chk("t1_sof", sof_o_a, (k == 0));
            chk("t1_tok", tok_o_a, UNANCH ? 1'b1 : (k == 0));
            @(negedge clk);
        end
        for (int k = 9; k <= 31; k++) begin
            chk("t1_ready", in_ready_a, (k == 31));
            chk("t1_busy", busy_a, (k != 31));
            if (k < 31) @(negedge clk);
        end

        // back-to-back 0xA5, 0x3C
        in_data_a = 8'hA5; in_last_a = 1'b0; in_valid_a = 1'b1;
        @(negedge clk);
        in_data_a = 8'h3C; in_last_a = 1'b1;
        pat = 16'b1010010100111100;
        for (int k = 0; k < 16; k++) begin
            chk("t2_bit", bit_o_a, pat[15-k]);
            chk("t2_valid", bit_valid_a, 1);
            chk("t2_ready", in_ready_a, (k == 7));
            chk("t2_sof", sof_o_a, (k == 0));
            @(negedge clk);
            if (k == 7) in_valid_a = 1'b0;
        end
        wait_idle(0);

        // 0x0F: token per bit only in unanchored mode
        send(0, 8'h0F, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("t3_tok", tok_o_a, UNANCH ? 1'b1 : (k == 0));
            chk("t3_sof", sof_o_a, (k == 0));
            chk("t3_bit", bit_o_a, (k >= 4));
            @(negedge clk);
        end
        wait_idle(0);

        // 0x80 then a 5-cycle WAIT, then 0x01 continues the string
        send(0, 8'h80, 1'b0);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("t5_wait_valid", bit_valid_a, 0);
            chk("t5_wait_ready", in_ready_a, 1);
            chk("t5_wait_busy", busy_a, 1);
            @(negedge clk);
        end
        send(0, 8'h01, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("t5_sof", sof_o_a, 0);
            chk("t5_bit", bit_o_a, (k == 7));
            @(negedge clk);
        end
        wait_idle(0);

        // reset mid-byte
        send(0, 8'hC3, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("t4_async_clear", {in_ready_a, bit_valid_a, bit_o_a, tok_o_a, sof_o_a, busy_a}, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("t4_ready", in_ready_a, 1);
        chk("t4_busy", busy_a, 0);
        send(0, 8'h5A, 1'b1);
        chk("t4_sof", sof_o_a, 1);
        chk("t4_bit", bit_o_a, 0);
        wait_idle(0);

        // LSB-first, no flush gap
        send(1, 8'h35, 1'b1);
        lit = 8'b10101100;
        for (int k = 0; k < 8; k++) begin
            chk("t6_bit", bit_o_b, lit[7-k]);
            chk("t6_sof", sof_o_b, (k == 0));
            @(negedge clk);
        end
        chk("t6_ready", in_ready_b, 1);
        chk("t6_busy", busy_b, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
